bus_master_port: RTL and testbench

//   Master-side arbitration endpoint for the 12-master split-transaction bus.
//   - Local master logic asks for the bus; this block raises m_req, waits for m_grant and drives bus_util while it owns the bus.
//   - Handles release, preemption by a higher-priority master, and slave split:
//     on split it drops the bus and waits for the arbiter's unsolicited re-grant.
//   - One instance per master, between the master datapath and the bus arbiter.

---
 rtl/bus_master_port_if.sv | 26 ++
 rtl/bus_master_port.sv | 138 +++++++++++++
 tb/tb_bus_master_port.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_master_port_if.sv
// Handshake bundle between a master datapath, its arbitration endpoint and the bus arbiter.
// The master modport is the endpoint's view. The slave modport is the view of the datapath and arbiter side.
interface bus_master_port_if;
   logic txn_start;
   logic txn_done;
   logic txn_abort;
   logic split_seen;
   logic m_grant;
   logic m_req;
   logic bus_util;
   logic granted;
   logic preempted;
   logic resume;
   logic split_active;
   logic timeout;

   modport master (
      input  txn_start, txn_done, txn_abort, split_seen, m_grant,
      output m_req, bus_util, granted, preempted, resume, split_active, timeout
   );

   modport slave (
      output txn_start, txn_done, txn_abort, split_seen, m_grant,
      input  m_req, bus_util, granted, preempted, resume, split_active, timeout
   );
endinterface

// File: rtl/bus_master_port.sv
// Master-side arbitration endpoint for a split-transaction bus: request, own, preemption, split park/resume.
// Optional REQ grant timeout is enabled by defining BMP_GRANT_TIMEOUT_EN.
module bus_master_port #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   bus_master_port_if.master     bus
);
   typedef enum logic [1:0] {IDLE, REQ, OWN, SPLIT_WAIT} state_t;

   // Counter width follows TIMEOUT_CYCLES, clamped to the 8..16 bit range.
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

   state_t state_q, state_d;
   logic   m_req_q, m_req_d;
   logic   bus_util_q, bus_util_d;
   logic   granted_q, granted_d;
   logic   preempted_q, preempted_d;
   logic   resume_q, resume_d;
   logic   split_active_q, split_active_d;
   logic   timeout_q, timeout_d;
   logic   [CNT_W-1:0] cnt_q, cnt_d;

`ifdef BMP_GRANT_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic cnt_expired;
   assign cnt_expired = (cnt_q == CNT_LAST);
`else
   logic cnt_expired;
   logic [CNT_W-1:0] unused_cnt;
   assign cnt_expired = 1'b0;
   assign unused_cnt  = cnt_q;
`endif

   always_comb begin
      state_d        = state_q;
      m_req_d        = m_req_q;
      bus_util_d     = bus_util_q;
      granted_d      = granted_q;
      split_active_d = split_active_q;
      preempted_d    = 1'b0;
      resume_d       = 1'b0;
      timeout_d      = 1'b0;
      cnt_d          = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.txn_start) begin
               state_d = REQ;
               m_req_d = 1'b1;
               cnt_d   = '0;
            end
         end
         REQ: begin
            if (bus.m_grant) begin
               state_d    = OWN;
               bus_util_d = 1'b1;
               granted_d  = 1'b1;
            end else if (bus.txn_abort) begin
               state_d = IDLE;
               m_req_d = 1'b0;
            end else if (cnt_expired) begin
               state_d   = IDLE;
               m_req_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OWN: begin
            if (bus.txn_done) begin
               state_d    = IDLE;
               m_req_d    = 1'b0;
               bus_util_d = 1'b0;
               granted_d  = 1'b0;
            end else if (bus.split_seen) begin
               state_d        = SPLIT_WAIT;
               m_req_d        = 1'b0;
               bus_util_d     = 1'b0;
               granted_d      = 1'b0;
               split_active_d = 1'b1;
            end else if (!bus.m_grant) begin
               // Preempted: keep requesting so the arbiter hands the bus back later.
               state_d     = REQ;
               bus_util_d  = 1'b0;
               granted_d   = 1'b0;
               preempted_d = 1'b1;
               cnt_d       = '0;
            end
         end
         SPLIT_WAIT: begin
            if (bus.m_grant) begin
               state_d        = OWN;
               m_req_d        = 1'b1;
               bus_util_d     = 1'b1;
               granted_d      = 1'b1;
               split_active_d = 1'b0;
               resume_d       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         m_req_q        <= 1'b0;
         bus_util_q     <= 1'b0;
         granted_q      <= 1'b0;
         preempted_q    <= 1'b0;
         resume_q       <= 1'b0;
         split_active_q <= 1'b0;
         timeout_q      <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         m_req_q        <= m_req_d;
         bus_util_q     <= bus_util_d;
         granted_q      <= granted_d;
         preempted_q    <= preempted_d;
         resume_q       <= resume_d;
         split_active_q <= split_active_d;
         timeout_q      <= timeout_d;
         cnt_q          <= cnt_d;
      end
   end

   assign bus.m_req        = m_req_q;
   assign bus.bus_util     = bus_util_q;
   assign bus.granted      = granted_q;
   assign bus.preempted    = preempted_q;
   assign bus.resume       = resume_q;
   assign bus.split_active = split_active_q;
   assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: basic ownership, preemption, split/resume, collisions, async reset, timeout.
module tb_bus_master_port;
   logic clk;
   logic rstn;
   int   n_assert;
   int   n_fail;

   bus_master_port_if bif ();

   bus_master_port #(.TIMEOUT_CYCLES(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
      $display("check %-24s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   // Checks every output against its expected value for the current cycle.
   task automatic chk_all(input string tag, input logic req, input logic util, input logic gnt,
                          input logic pre, input logic res, input logic spl, input logic tmo);
      chk({tag, ".m_req"}, bif.m_req, req);
      chk({tag, ".bus_util"}, bif.bus_util, util);
      chk({tag, ".granted"}, bif.granted, gnt);
      chk({tag, ".preempted"}, bif.preempted, pre);
      chk({tag, ".resume"}, bif.resume, res);
      chk({tag, ".split_active"}, bif.split_active, spl);
      chk({tag, ".timeout"}, bif.timeout, tmo);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rstn = 1'b0;
      bif.txn_start = 0; bif.txn_done = 0; bif.txn_abort = 0;
      bif.split_seen = 0; bif.m_grant = 0;
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      rstn = 1'b1;
      tick();
      chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

      // 1. basic request / grant / done
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      chk_all("t1_req", 1, 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("t1_wait", 1, 0, 0, 0, 0, 0, 0);
      bif.m_grant = 1; tick();
      chk_all("t1_own", 1, 1, 1, 0, 0, 0, 0);
      bif.txn_done = 1; tick(); bif.txn_done = 0;
      chk_all("t1_done", 0, 0, 0, 0, 0, 0, 0);
      // grant still high right after release must not start a new ownership
      tick();
      chk_all("t1_stale_grant", 0, 0, 0, 0, 0, 0, 0);
      bif.m_grant = 0;

      // 2. preemption and re-grant
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      bif.m_grant = 1; tick();
      chk_all("t2_own", 1, 1, 1, 0, 0, 0, 0);
      bif.m_grant = 0; tick();
      chk_all("t2_preempt", 1, 0, 0, 1, 0, 0, 0);
      tick();
      chk_all("t2_preempt_end", 1, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      bif.m_grant = 1; tick();
      chk_all("t2_regrant", 1, 1, 1, 0, 0, 0, 0);

      // 4b. txn_start during OWN is ignored
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      chk_all("t4_start_in_own", 1, 1, 1, 0, 0, 0, 0);

      // 3. split, abort ignored while parked, unsolicited re-grant
      bif.split_seen = 1; tick(); bif.split_seen = 0;
      chk_all("t3_split", 0, 0, 0, 0, 0, 1, 0);
      bif.m_grant = 0;
      bif.txn_abort = 1; tick(); bif.txn_abort = 0;
      chk_all("t3_abort_ignored", 0, 0, 0, 0, 0, 1, 0);
      bif.txn_done = 1; tick(); bif.txn_done = 0;
      chk_all("t3_done_ignored", 0, 0, 0, 0, 0, 1, 0);
      tick(); tick();
      bif.m_grant = 1; tick();
      chk_all("t3_resume", 1, 1, 1, 0, 1, 0, 0);
      tick();
      chk_all("t3_resume_end", 1, 1, 1, 0, 0, 0, 0);

      // 4a. txn_done collides with grant loss: done wins
      bif.txn_done = 1; bif.m_grant = 0; tick(); bif.txn_done = 0;
      chk_all("t4_done_vs_loss", 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("t4_no_preempt", 0, 0, 0, 0, 0, 0, 0);

      // split collides with grant loss: split wins
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      bif.m_grant = 1; tick();
      bif.split_seen = 1; bif.m_grant = 0; tick(); bif.split_seen = 0;
      chk_all("t4_split_vs_loss", 0, 0, 0, 0, 0, 1, 0);
      bif.m_grant = 1; tick();
      chk_all("t4_split_resume", 1, 1, 1, 0, 1, 0, 0);

      // abort withdraws a pending request
      bif.txn_done = 1; bif.m_grant = 0; tick(); bif.txn_done = 0;
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      chk("abort_pre.m_req", bif.m_req, 1'b1);
      bif.txn_abort = 1; tick(); bif.txn_abort = 0;
      chk_all("abort", 0, 0, 0, 0, 0, 0, 0);

      // 5. async reset mid-OWN, then IDLE ignores a stray grant
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      bif.m_grant = 1; tick();
      chk_all("t5_own", 1, 1, 1, 0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      chk_all("t5_async_reset", 0, 0, 0, 0, 0, 0, 0);
      tick();
      #2 rstn = 1'b1;
      tick(); tick();
      chk_all("t5_idle_grant", 0, 0, 0, 0, 0, 0, 0);
      bif.m_grant = 0;

`ifdef BMP_GRANT_TIMEOUT_EN
      // 6a. no grant: timeout after 8 REQ cycles
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      for (int i = 0; i < 7; i++) tick();
      chk_all("t6_before_timeout", 1, 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("t6_timeout", 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk_all("t6_timeout_end", 0, 0, 0, 0, 0, 0, 0);
      // 6b. grant on the 8th REQ cycle wins
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      for (int i = 0; i < 7; i++) tick();
      bif.m_grant = 1; tick();
      chk_all("t6_grant_wins", 1, 1, 1, 0, 0, 0, 0);
      tick();
      chk("t6_no_late_timeout", bif.timeout, 1'b0);
      bif.txn_done = 1; bif.m_grant = 0; tick(); bif.txn_done = 0;
`else
      // without the timeout feature REQ waits indefinitely
      bif.txn_start = 1; tick(); bif.txn_start = 0;
      for (int i = 0; i < 20; i++) tick();
      chk_all("no_timeout_wait", 1, 0, 0, 0, 0, 0, 0);
      bif.m_grant = 1; tick();
      chk_all("no_timeout_grant", 1, 1, 1, 0, 0, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
